// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings and constants for the divider arbiter
package div_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        DRAIN = 2'b10,
        RESP  = 2'b11
    } state_t;

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUO = '1;

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - register primitive with synchronous active-high clear to zero
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker, searches upward from ptr with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic found;

    // Both loops are constant-bounded so every vector index stays static.
    always_comb begin
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % NUM_REQ))) begin
                    found     = 1'b1;
                    grant[j]  = 1'b1;
                    grant_idx = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - shares one Start/Done divider among NUM_REQ requesters, round-robin
module div_arbiter
    import div_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = DIV_WIDTH,
    parameter int IDX_W   = 1
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NUM_REQ-1:0]       Req_Valid,
    output logic [NUM_REQ-1:0]       Req_Ready,
    input  logic [NUM_REQ*WIDTH-1:0] Req_Dividend,
    input  logic [NUM_REQ*WIDTH-1:0] Req_Divisor,
    output logic [NUM_REQ-1:0]       Rsp_Valid,
    output logic [WIDTH-1:0]         Rsp_Quotient,
    output logic [WIDTH-1:0]         Rsp_Remainder,
    output logic                     Rsp_DivZero,
    output logic                     Busy,
    output logic                     Div_Start,
    output logic [WIDTH-1:0]         Div_Dividend,
    output logic [WIDTH-1:0]         Div_Divisor,
    input  logic [WIDTH-1:0]         Div_Quotient,
    input  logic [WIDTH-1:0]         Div_Remainder,
    input  logic                     Div_Done
);

    state_t             state_q, state_d;
    logic [1:0]         state_raw;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
    logic [WIDTH-1:0]   quo_q, quo_d, rem_q, rem_d;
    logic               dz_q, dz_d;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [WIDTH-1:0]   sel_dvd, sel_dvs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (Req_Valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_dvd = '0;
        sel_dvs = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_dvd = Req_Dividend[i*WIDTH +: WIDTH];
                sel_dvs = Req_Divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    dff #(.W(2))     u_state (.clk(Clock), .rst(Reset), .d(state_d), .q(state_raw));
    dff #(.W(IDX_W)) u_ptr   (.clk(Clock), .rst(Reset), .d(ptr_d),   .q(ptr_q));
    dff #(.W(IDX_W)) u_grant (.clk(Clock), .rst(Reset), .d(grant_d), .q(grant_q));
    dff #(.W(WIDTH)) u_dvd   (.clk(Clock), .rst(Reset), .d(dvd_d),   .q(dvd_q));
    dff #(.W(WIDTH)) u_dvs   (.clk(Clock), .rst(Reset), .d(dvs_d),   .q(dvs_q));
    dff #(.W(WIDTH)) u_quo   (.clk(Clock), .rst(Reset), .d(quo_d),   .q(quo_q));
    dff #(.W(WIDTH)) u_rem   (.clk(Clock), .rst(Reset), .d(rem_d),   .q(rem_q));
    dff #(.W(1))     u_dz    (.clk(Clock), .rst(Reset), .d(dz_d),    .q(dz_q));

    assign state_q = state_t'(state_raw);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        Req_Ready = '0;
        Rsp_Valid = '0;
        Div_Start = 1'b0;
        case (state_q)
            IDLE: begin
                Req_Ready = arb_grant;
                if (|(Req_Valid & arb_grant)) begin
                    grant_d = arb_idx;
                    dvd_d   = sel_dvd;
                    dvs_d   = sel_dvs;
                    // Divide-by-zero is answered locally; the divider never sees it.
                    if (sel_dvs == '0) begin
                        quo_d   = DIV_ZERO_QUO;
                        rem_d   = sel_dvd;
                        dz_d    = 1'b1;
                        state_d = RESP;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                Div_Start = 1'b1;
                if (Div_Done) begin
                    quo_d   = Div_Quotient;
                    rem_d   = Div_Remainder;
                    state_d = DRAIN;
                end
            end
            // Wait out the old Done level so it cannot complete the next job.
            DRAIN: begin
                if (!Div_Done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                Rsp_Valid = NUM_REQ'(1) << grant_q;
                ptr_d     = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy          = (state_q != IDLE);
    assign Div_Dividend  = dvd_q;
    assign Div_Divisor   = dvs_q;
    assign Rsp_Quotient  = quo_q;
    assign Rsp_Remainder = rem_q;
    assign Rsp_DivZero   = (state_q == RESP) && dz_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter with a behavioural divider
module tb_div_arbiter;

    logic        Clock;
    logic        Reset;
    logic [1:0]  Req_Valid;
    logic [1:0]  Req_Ready;
    logic [31:0] Req_Dividend;
    logic [31:0] Req_Divisor;
    logic [1:0]  Rsp_Valid;
    logic [15:0] Rsp_Quotient;
    logic [15:0] Rsp_Remainder;
    logic        Rsp_DivZero;
    logic        Busy;
    logic        Div_Start;
    logic [15:0] Div_Dividend;
    logic [15:0] Div_Divisor;
    logic [15:0] Div_Quotient;
    logic [15:0] Div_Remainder;
    logic        Div_Done;

    int checks = 0;
    int errors = 0;

    logic        force_done;
    logic        m_done;
    logic [2:0]  m_cnt;

    div_arbiter #(.NUM_REQ(2), .WIDTH(16), .IDX_W(1)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .Req_Valid     (Req_Valid),
        .Req_Ready     (Req_Ready),
        .Req_Dividend  (Req_Dividend),
        .Req_Divisor   (Req_Divisor),
        .Rsp_Valid     (Rsp_Valid),
        .Rsp_Quotient  (Rsp_Quotient),
        .Rsp_Remainder (Rsp_Remainder),
        .Rsp_DivZero   (Rsp_DivZero),
        .Busy          (Busy),
        .Div_Start     (Div_Start),
        .Div_Dividend  (Div_Dividend),
        .Div_Divisor   (Div_Divisor),
        .Div_Quotient  (Div_Quotient),
        .Div_Remainder (Div_Remainder),
        .Div_Done      (Div_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Divider model: Done rises 4 cycles into Start, falls one cycle after Start drops.
    always @(posedge Clock) begin
        if (Reset) begin
            m_cnt  <= 3'd0;
            m_done <= 1'b0;
        end else if (Div_Start && !m_done) begin
            if (m_cnt == 3'd3) begin
                m_done        <= 1'b1;
                m_cnt         <= 3'd0;
                Div_Quotient  <= Div_Dividend / Div_Divisor;
                Div_Remainder <= Div_Dividend % Div_Divisor;
            end else begin
                m_cnt <= m_cnt + 3'd1;
            end
        end else if (!Div_Start) begin
            m_done <= 1'b0;
        end
    end

    assign Div_Done = m_done | force_done;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 40; i++) begin
            if (Rsp_Valid != 2'b00) break;
            step();
        end
    endtask

    task automatic pulse_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        Reset        = 1'b1;
        Req_Valid    = 2'b00;
        Req_Dividend = '0;
        Req_Divisor  = '0;
        force_done   = 1'b0;
        Div_Quotient  = '0;
        Div_Remainder = '0;
        step();
        step();

        check("rst_ready", Req_Ready, 0);
        check("rst_rsp_valid", Rsp_Valid, 0);
        check("rst_start", Div_Start, 0);
        check("rst_busy", Busy, 0);
        check("rst_divzero", Rsp_DivZero, 0);
        check("rst_quo", Rsp_Quotient, 0);
        check("rst_div_dvd", Div_Dividend, 0);
        Reset = 1'b0;
        step();

        // Single job 100 / 7
        Req_Valid          = 2'b01;
        Req_Dividend[15:0] = 16'd100;
        Req_Divisor[15:0]  = 16'd7;
        #1;
        check("t1_ready", Req_Ready, 2'b01);
        step();
        Req_Valid = 2'b00;
        check("t1_busy", Busy, 1);
        check("t1_start", Div_Start, 1);
        check("t1_div_dvd", Div_Dividend, 100);
        check("t1_div_dvs", Div_Divisor, 7);
        for (int i = 0; i < 20; i++) begin
            if (Div_Done) break;
            step();
        end
        check("t1_done_seen", Div_Done, 1);
        step();
        check("t1_start_fall", Div_Start, 0);
        wait_rsp();
        check("t1_rsp_valid", Rsp_Valid, 2'b01);
        check("t1_quo", Rsp_Quotient, 14);
        check("t1_rem", Rsp_Remainder, 2);
        check("t1_dz", Rsp_DivZero, 0);
        step();
        check("t1_rsp_pulse", Rsp_Valid, 0);
        check("t1_idle", Busy, 0);

        // Two requesters from pointer 0
        pulse_reset();
        Req_Dividend = {16'd1000, 16'd65535};
        Req_Divisor  = {16'd33, 16'd1};
        Req_Valid    = 2'b11;
        wait_rsp();
        check("t2_rsp0_valid", Rsp_Valid, 2'b01);
        check("t2_rsp0_quo", Rsp_Quotient, 65535);
        check("t2_rsp0_rem", Rsp_Remainder, 0);
        step();
        check("t2_gap_rsp", Rsp_Valid, 0);
        check("t2_gap_busy", Busy, 0);
        check("t2_ready1", Req_Ready, 2'b10);
        step();
        wait_rsp();
        Req_Valid = 2'b00;
        check("t2_rsp1_valid", Rsp_Valid, 2'b10);
        check("t2_rsp1_quo", Rsp_Quotient, 30);
        check("t2_rsp1_rem", Rsp_Remainder, 10);
        step();

        // Divide by zero on requester 0 (pointer is back at 0)
        Req_Dividend[15:0] = 16'd1234;
        Req_Divisor[15:0]  = 16'd0;
        Req_Valid          = 2'b01;
        #1;
        check("t3_ready", Req_Ready, 2'b01);
        step();
        Req_Valid = 2'b00;
        check("t3_rsp_valid", Rsp_Valid, 2'b01);
        check("t3_quo", Rsp_Quotient, 16'hFFFF);
        check("t3_rem", Rsp_Remainder, 1234);
        check("t3_dz", Rsp_DivZero, 1);
        check("t3_start", Div_Start, 0);
        step();
        check("t3_after_rsp", Rsp_Valid, 0);
        check("t3_after_start", Div_Start, 0);

        // Fairness: six jobs with both valid
        pulse_reset();
        Req_Dividend = {16'd9, 16'd20};
        Req_Divisor  = {16'd2, 16'd3};
        Req_Valid    = 2'b11;
        for (int j = 0; j < 6; j++) begin
            wait_rsp();
            check("t4_grant", Rsp_Valid, (j % 2 == 0) ? 2'b01 : 2'b10);
            check("t4_quo", Rsp_Quotient, (j % 2 == 0) ? 6 : 4);
            if (j == 5) Req_Valid = 2'b00;
            step();
            check("t4_busy_gap", Busy, 0);
            step();
            check("t4_busy_again", Busy, (j == 5) ? 0 : 1);
        end

        // Reset in the middle of BUSY
        Req_Dividend[15:0] = 16'd50;
        Req_Divisor[15:0]  = 16'd3;
        Req_Valid          = 2'b01;
        step();
        Req_Valid = 2'b00;
        step();
        check("t5_start_pre", Div_Start, 1);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("t5_busy", Busy, 0);
        check("t5_start", Div_Start, 0);
        check("t5_rsp", Rsp_Valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            check("t5_no_rsp", Rsp_Valid, 0);
        end
        Req_Dividend[15:0] = 16'd9;
        Req_Divisor[15:0]  = 16'd4;
        Req_Valid          = 2'b01;
        step();
        Req_Valid = 2'b00;
        wait_rsp();
        check("t5_new_valid", Rsp_Valid, 2'b01);
        check("t5_new_quo", Rsp_Quotient, 2);
        check("t5_new_rem", Rsp_Remainder, 1);
        step();

        // Stray Done in IDLE
        force_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_busy", Busy, 0);
            check("t6_rsp", Rsp_Valid, 0);
            check("t6_start", Div_Start, 0);
        end
        force_done = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one 16-bit restoring divider (Start/Done level handshake) among NUM_REQ requesters.
- Arbitrates round-robin, latches the winner's operands and sequences the divider's Start/Done protocol.
- Returns results to the winner as a one-cycle response pulse.
- Handles divide-by-zero locally without starting the divider.
- Sits between client blocks and the divider core, on the same clock and reset.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 16, operand and result width; must match the divider.
- IDX_W, 1, grant-index width, equal to ceil(log2(NUM_REQ)).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req_Valid  in  NUM_REQ  per-requester request valid.
- Req_Ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- Req_Dividend  in  NUM_REQ*WIDTH  packed dividends; requester i occupies slice i.
- Req_Divisor  in  NUM_REQ*WIDTH  packed divisors.
- Rsp_Valid  out  NUM_REQ  one-hot, one-cycle result pulse to the owning requester.
- Rsp_Quotient  out  WIDTH  result quotient; valid while Rsp_Valid is nonzero.
- Rsp_Remainder  out  WIDTH  result remainder.
- Rsp_DivZero  out  1  set with Rsp_Valid when the latched divisor was 0.
- Busy  out  1  high in any state other than IDLE.
- Div_Start  out  1  divider start; held high until Div_Done is seen.
- Div_Dividend  out  WIDTH  latched dividend to the divider.
- Div_Divisor  out  WIDTH  latched divisor to the divider.
- Div_Quotient  in  WIDTH  divider quotient.
- Div_Remainder  in  WIDTH  divider remainder.
- Div_Done  in  1  divider done level.

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named Clock and Reset.
- Reset values:
  - state IDLE, round-robin pointer 0.
  - Req_Ready, Rsp_Valid, Div_Start, Rsp_DivZero and Busy all 0.
  - Latched operands, results and grant index all 0.
- States: IDLE, BUSY, DRAIN, RESP.
- IDLE:
  - Winner is the first requester with Req_Valid, searching from the pointer upward with wrap-around.
  - Req_Ready is asserted combinationally for the winner only. Handshake = Req_Valid & Req_Ready.
  - On handshake, latch the winner's dividend, divisor and index.
  - If divisor == 0: next state RESP, quotient = all ones, remainder = dividend, DivZero = 1. Div_Start is never raised.
  - Otherwise: next state BUSY.
- BUSY:
  - Div_Start = 1; Div_Dividend and Div_Divisor are driven from the latches and stay stable.
  - When Div_Done = 1, capture Div_Quotient and Div_Remainder and go to DRAIN.
- DRAIN:
  - Div_Start = 0. Wait for Div_Done = 0; the divider leaves its done state only after Start drops.
  - Then go to RESP. This guarantees a stale Done is never taken for the next job.
- RESP:
  - Rsp_Valid[grant] = 1 for exactly one cycle, with results and DivZero.
  - Pointer = grant + 1, modulo NUM_REQ. Next state IDLE.
  - No new request is accepted in RESP.
- Latency:
  - Divide-by-zero: response 1 cycle after the handshake cycle.
  - Normal: response 1 cycle after the cycle Div_Done is first seen low in DRAIN.
- Fairness: with every requester continuously valid, grants rotate 0, 1, …, NUM_REQ-1, 0.
- Req_Valid dropped in the same cycle as the handshake: the job still completes. A requester not granted may change its operands freely.
- Reset during BUSY or DRAIN: return to IDLE next cycle with Div_Start = 0 and no Rsp_Valid. The divider shares Reset, so it also returns to its idle state.
- Div_Done high while in IDLE: ignored.
- Results are unsigned, WIDTH bits. The divider's internal 17-bit remainder is not exposed.

Decomposition:
- Shared package div_pkg holds:
  - state encodings IDLE = 2'b00, BUSY = 2'b01, DRAIN = 2'b10, RESP = 2'b11.
  - DIV_WIDTH = 16.
  - The all-ones divide-by-zero quotient constant.
- Sub-module rr_arbiter (NUM_REQ): inputs request vector and pointer; output one-hot grant and encoded index. It is combinational and reusable by other shared-resource controllers.
- State, pointer and latches use the codebase DFF primitive.

Test Plan:
- Req_Valid = 01, 100 / 7 → one divider job; Rsp_Valid = 01, Q = 14, R = 2, DivZero = 0; Div_Start falls after Div_Done rises.
- Req_Valid = 11 held with pointer 0, ops0 = 65535 / 1, ops1 = 1000 / 33 → first Rsp_Valid = 01 with Q = 65535, R = 0; then Rsp_Valid = 10 with Q = 30, R = 10; no overlap between the two jobs.
- Req_Valid = 01, 1234 / 0 → Div_Start stays 0; Rsp_Valid = 01 one cycle after handshake with Q = 0xFFFF, R = 1234, DivZero = 1.
- Both requesters continuously valid for 6 jobs → grant order 0, 1, 0, 1, 0, 1; Busy low for exactly one cycle between responses.
- Reset pulsed mid-BUSY on job 50 / 3 → next cycle IDLE, Div_Start = 0, no Rsp_Valid; a new 9 / 4 request then returns Q = 2, R = 1.
- Div_Done forced high in IDLE with no requests → no state change, Rsp_Valid stays 0.
